// File: rtl/pipeline_types_pkg.sv
// Shared request/echo bus types for the control path.
package pipeline_types;

  typedef struct packed {
    logic rising;
    logic falling;
  } control_path_t;

  localparam control_path_t RESET_VALUES_CONTROL_PATH = '{rising: 1'b0, falling: 1'b0};

endpackage : pipeline_types

// File: rtl/output_shaper_if.sv
// Request and shaped-output bundle for output_shaper.
interface output_shaper_if;
  import pipeline_types::*;

  control_path_t i_control;
  control_path_t o_control;
  logic          o_signal;
  logic          o_busy;
  logic          o_dropped;

  modport master (output i_control, input o_control, o_signal, o_busy, o_dropped);
  modport slave  (input i_control, output o_control, o_signal, o_busy, o_dropped);

endinterface : output_shaper_if

// File: rtl/output_shaper.sv
// Drives one registered level from rising/falling requests, holding every level
// for at least MIN_HOLD_CYCLES clocks and coalescing requests made during a hold.
module output_shaper
  import pipeline_types::*;
#(
  parameter int unsigned MIN_HOLD_CYCLES = 5,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  output_shaper_if.slave    shp
);

  localparam int unsigned CNT_W = (MIN_HOLD_CYCLES > 1) ? $clog2(MIN_HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(MIN_HOLD_CYCLES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_e;

  logic             level_q,   level_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             pending_q, pending_d;
  control_path_t    ctrl_q,    ctrl_d;
  logic             dropped_q, dropped_d;

  state_e state_c;
  logic   req_up_c, req_dn_c, illegal_c, pend_eff_c;

  // A pending flag only lives inside a hold, so the counter alone picks the state.
  assign state_c = (cnt_q != '0) ? ST_HOLD : ST_IDLE;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level_q   <= RESET_LEVEL;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      ctrl_q    <= RESET_VALUES_CONTROL_PATH;
      dropped_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ctrl_q    <= ctrl_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    level_d    = level_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    ctrl_d     = RESET_VALUES_CONTROL_PATH;
    dropped_d  = 1'b0;
    req_up_c   = shp.i_control.rising & ~shp.i_control.falling;
    req_dn_c   = shp.i_control.falling & ~shp.i_control.rising;
    illegal_c  = shp.i_control.rising & shp.i_control.falling;
    pend_eff_c = pending_q;

    // Merge the incoming request with any queued transition toward ~level.
    if (illegal_c) begin
      dropped_d = 1'b1;
    end else if (req_up_c || req_dn_c) begin
      if (req_up_c != level_q) begin
        pend_eff_c = 1'b1;
      end else if (pending_q) begin
        pend_eff_c = 1'b0;
        dropped_d  = 1'b1;
      end
    end

    if (state_c == ST_IDLE && pend_eff_c) begin
      level_d        = ~level_q;
      cnt_d          = HOLD_RELOAD;
      pending_d      = 1'b0;
      ctrl_d.rising  = ~level_q;
      ctrl_d.falling = level_q;
    end else begin
      pending_d = pend_eff_c;
      if (state_c == ST_HOLD) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  assign shp.o_signal  = level_q;
  assign shp.o_control = ctrl_q;
  assign shp.o_dropped = dropped_q;
  assign shp.o_busy    = (cnt_q != '0) | pending_q;

endmodule : output_shaper
